// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, clock-filter default,
// odd-parity helper and the scan-code / command constants used by the
// receiver and keypad decode path.
package ps2_pkg;

   // Default number of consecutive equal ps2c samples needed to move the filtered clock
   localparam int unsigned FILTER_LEN_DEF = 8;

   // Transmitter states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RTS   = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_t;

   // Host commands
   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_RESET    = 8'hFF;

   // Device responses and scan-code prefixes seen by the receiver
   localparam logic [7:0] SC_ACK       = 8'hFA;
   localparam logic [7:0] SC_BREAK     = 8'hF0;
   localparam logic [7:0] SC_EXTEND    = 8'hE0;
   localparam logic [7:0] SC_BAT_OK    = 8'hAA;

   // Parity bit that makes the 9-bit word {parity, d} contain an odd number of ones
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the sampled PS/2 clock line and flags its falling edges.
// Shared by the PS/2 receiver and transmitter.
//   clk, reset   : system clock, synchronous active-high reset
//   ps2c_in      : raw sampled PS/2 clock line
//   f_clk        : filtered clock level (registered)
//   fall_edge_c  : combinational, high in the cycle the filtered clock drops
module ps2_clk_filter
   import ps2_pkg::*;
#(
   parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c_in,
   output logic f_clk,
   output logic fall_edge_c
);

   logic [FILTER_LEN-1:0] filter_reg;
   logic [FILTER_LEN-1:0] filter_next;
   logic                  f_next;

   // Filter state
   always_ff @(posedge clk) begin
      if (reset) begin
         filter_reg <= '0;
         f_clk      <= 1'b0;
      end else begin
         filter_reg <= filter_next;
         f_clk      <= f_next;
      end
   end

   // Filtered level only moves once the whole window agrees; otherwise it holds
   always_comb begin
      filter_next = {ps2c_in, filter_reg[FILTER_LEN-1:1]};
      f_next      = f_clk;
      if (&filter_next) begin
         f_next = 1'b1;
      end else if (~|filter_next) begin
         f_next = 1'b0;
      end
      fall_edge_c = f_clk & ~f_next;
   end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then start bit, 8 data
// bits LSB-first, odd parity and stop bit clocked out by the device, then the
// device acknowledge is sampled. A watchdog aborts a stalled transfer.
//   clk, reset        : system clock, synchronous active-high reset
//   wr_ps2, din       : start strobe and byte to send (accepted only when idle)
//   ps2c_in, ps2d_in  : sampled PS/2 clock / data lines
//   ps2c_oe, ps2d_oe  : 1 = pull the line low, 0 = release
//   tx_idle           : high while idle (gates the receiver)
//   tx_done_tick      : one-cycle pulse once the ack has been sampled
//   ack_err           : with tx_done_tick, 1 = device did not ack
//   tx_err            : one-cycle pulse on watchdog timeout
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int unsigned RTS_CYCLES     = 5000,
   parameter int unsigned FILTER_LEN     = FILTER_LEN_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_oe,
   output logic       ps2d_oe,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       ack_err,
   output logic       tx_err
);

   localparam int unsigned RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
   localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   tx_state_t        state_reg, state_next;
   logic [8:0]       b_reg, b_next;
   logic [3:0]       n_reg, n_next;
   logic [RTS_W-1:0] rts_reg, rts_next;
   logic [WD_W-1:0]  wd_reg, wd_next;

   logic ps2c_oe_next, ps2d_oe_next, tx_idle_next;
   logic tx_done_next, ack_err_next, tx_err_next;
   logic wd_expired_c;
   logic fall_edge_c;
   logic f_clk_unused;

   // The filtered level itself is only needed by the receiver
   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk         (clk),
      .reset       (reset),
      .ps2c_in     (ps2c_in),
      .f_clk       (f_clk_unused),
      .fall_edge_c (fall_edge_c)
   );

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         b_reg        <= '0;
         n_reg        <= '0;
         rts_reg      <= '0;
         wd_reg       <= '0;
         ps2c_oe      <= 1'b0;
         ps2d_oe      <= 1'b0;
         tx_idle      <= 1'b1;
         tx_done_tick <= 1'b0;
         ack_err      <= 1'b0;
         tx_err       <= 1'b0;
      end else begin
         state_reg    <= state_next;
         b_reg        <= b_next;
         n_reg        <= n_next;
         rts_reg      <= rts_next;
         wd_reg       <= wd_next;
         ps2c_oe      <= ps2c_oe_next;
         ps2d_oe      <= ps2d_oe_next;
         tx_idle      <= tx_idle_next;
         tx_done_tick <= tx_done_next;
         ack_err      <= ack_err_next;
         tx_err       <= tx_err_next;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_next   = state_reg;
      b_next       = b_reg;
      n_next       = n_reg;
      rts_next     = rts_reg;
      wd_next      = wd_reg;
      tx_done_next = 1'b0;
      tx_err_next  = 1'b0;
      ack_err_next = ack_err;
      wd_expired_c = (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

      case (state_reg)
         ST_IDLE: begin
            if (wr_ps2) begin
               b_next     = {odd_parity(din), din};
               rts_next   = RTS_W'(RTS_CYCLES - 1);
               state_next = ST_RTS;
            end
         end
         ST_RTS: begin
            if (rts_reg == '0) begin
               wd_next    = '0;
               state_next = ST_START;
            end else begin
               rts_next = rts_reg - RTS_W'(1);
            end
         end
         ST_START, ST_DATA, ST_STOP: begin
            // Watchdog takes priority over a same-cycle device edge
            if (wd_expired_c) begin
               tx_err_next = 1'b1;
               state_next  = ST_IDLE;
            end else begin
               wd_next = wd_reg + WD_W'(1);
               if (fall_edge_c) begin
                  if (state_reg == ST_START) begin
                     n_next     = 4'd8;
                     state_next = ST_DATA;
                  end else if (state_reg == ST_DATA) begin
                     if (n_reg == 4'd0) begin
                        state_next = ST_STOP;
                     end else begin
                        b_next = {1'b0, b_reg[8:1]};
                        n_next = n_reg - 4'd1;
                     end
                  end else begin
                     ack_err_next = ps2d_in;
                     tx_done_next = 1'b1;
                     state_next   = ST_IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // Outputs decoded from the upcoming state so they change with it
      ps2c_oe_next = (state_next == ST_RTS);
      ps2d_oe_next = (state_next == ST_START) || ((state_next == ST_DATA) && !b_next[0]);
      tx_idle_next = (state_next == ST_IDLE);
   end

endmodule
